// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the RUN/HALT machine and feeds the IF side of IF/ID.
// Handles load-use stalls, ID-stage redirects, halt-word parking and fetch/stall counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isLWHazard,
    input  logic        BranchTakenD,
    input  logic [31:0] BranchTargetD,
    input  logic        JumpD,
    input  logic [31:0] JumpTargetD,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] PCF,
    output logic [31:0] PC4,
    output logic [31:0] InstructionF,
    output logic        StopF,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc_nxt;
    logic [XLEN-1:0]   fetch_nxt;
    logic [XLEN-1:0]   stall_nxt;
    logic              redirect;
    logic [XLEN-1:0]   target;

    assign redirect  = BranchTakenD | JumpD;
    // Branch wins over jump; targets are always word aligned.
    assign target    = BranchTakenD ? {BranchTargetD[XLEN-1:2], 2'b00}
                                    : {JumpTargetD[XLEN-1:2], 2'b00};
    assign imem_addr = PCF;
    assign PC4       = PCF + XLEN'(4);
    assign halted    = (state == HALT);

    // State, PC and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            PCF       <= RESET_PC;
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            PCF       <= pc_nxt;
            fetch_cnt <= fetch_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // Next-state and IF/ID payload selection.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = PCF;
        fetch_nxt    = fetch_cnt;
        stall_nxt    = stall_cnt;
        InstructionF = imem_rdata;
        StopF        = 1'b0;

        case (state)
            RUN: begin
                if (isLWHazard) begin
                    stall_nxt = stall_cnt + XLEN'(1);
                end else if (redirect) begin
                    InstructionF = '0;
                    pc_nxt       = target;
                end else if (imem_rdata == HALT_WORD) begin
                    InstructionF = '0;
                    StopF        = 1'b1;
                    state_nxt    = HALT;
                end else begin
                    pc_nxt    = PCF + XLEN'(4);
                    fetch_nxt = fetch_cnt + XLEN'(1);
                end
            end
            HALT: begin
                InstructionF = '0;
                StopF        = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, fetch, stall, redirect, halt and PC wrap.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        isLWHazard;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        JumpD;
    logic [31:0] JumpTargetD;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] PCF;
    logic [31:0] PC4;
    logic [31:0] InstructionF;
    logic        StopF;
    logic        halted;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int vectors;
    int miscompares;

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .isLWHazard   (isLWHazard),
        .BranchTakenD (BranchTakenD),
        .BranchTargetD(BranchTargetD),
        .JumpD        (JumpD),
        .JumpTargetD  (JumpTargetD),
        .imem_rdata   (imem_rdata),
        .imem_addr    (imem_addr),
        .PCF          (PCF),
        .PC4          (PC4),
        .InstructionF (InstructionF),
        .StopF        (StopF),
        .halted       (halted),
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        isLWHazard    = 1'b0;
        BranchTakenD  = 1'b0;
        BranchTargetD = '0;
        JumpD         = 1'b0;
        JumpTargetD   = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        imem_rdata  = 32'h0;
        clr_in();

        // Reset for two edges
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_pcf",    PCF,                32'h0);
        chk("rst_pc4",    PC4,                32'h4);
        chk("rst_iaddr",  imem_addr,          32'h0);
        chk("rst_halted", 32'(halted),        32'h0);
        chk("rst_stopf",  32'(StopF),         32'h0);
        chk("rst_fcnt",   fetch_cnt,          32'h0);
        chk("rst_scnt",   stall_cnt,          32'h0);

        // Sequential fetch
        imem_rdata = 32'h2001_0005;
        #1;
        chk("seq0_instr", InstructionF, 32'h2001_0005);
        step();
        chk("seq0_pcf",   PCF, 32'h4);
        imem_rdata = 32'h2002_0003;
        #1;
        chk("seq1_instr", InstructionF, 32'h2002_0003);
        chk("seq1_pc4",   PC4, 32'h8);
        step();
        chk("seq1_pcf",   PCF, 32'h8);
        imem_rdata = 32'h0000_0000;
        #1;
        chk("seq2_instr", InstructionF, 32'h0);
        chk("seq2_stopf", 32'(StopF), 32'h0);
        step();
        chk("seq2_pcf",   PCF, 32'hC);
        chk("seq2_pc4",   PC4, 32'h10);
        chk("seq_fcnt",   fetch_cnt, 32'd3);

        // Load-use stall at PCF=C
        isLWHazard = 1'b1;
        imem_rdata = 32'h1111_1111;
        #1;
        chk("stall_instr", InstructionF, 32'h1111_1111);
        chk("stall_stopf", 32'(StopF), 32'h0);
        step();
        chk("stall_pcf",  PCF, 32'hC);
        chk("stall_scnt", stall_cnt, 32'd1);
        chk("stall_fcnt", fetch_cnt, 32'd3);
        isLWHazard = 1'b0;
        imem_rdata = 32'h0000_0013;
        step();
        chk("post_stall_pcf",  PCF, 32'h10);
        chk("post_stall_fcnt", fetch_cnt, 32'd4);

        // Branch redirect at PCF=10
        BranchTakenD  = 1'b1;
        BranchTargetD = 32'h40;
        imem_rdata    = 32'h2222_2222;
        #1;
        chk("br_instr", InstructionF, 32'h0);
        step();
        chk("br_pcf",  PCF, 32'h40);
        chk("br_fcnt", fetch_cnt, 32'd4);
        clr_in();

        // Jump with misaligned target
        JumpD       = 1'b1;
        JumpTargetD = 32'h103;
        #1;
        chk("jmp_instr", InstructionF, 32'h0);
        step();
        chk("jmp_pcf",  PCF, 32'h100);
        chk("jmp_fcnt", fetch_cnt, 32'd4);

        // Branch and jump together: branch wins
        BranchTakenD  = 1'b1;
        BranchTargetD = 32'h14;
        JumpD         = 1'b1;
        JumpTargetD   = 32'h200;
        step();
        chk("brjmp_pcf", PCF, 32'h14);
        clr_in();

        // Stall collides with redirect at PCF=14
        isLWHazard    = 1'b1;
        BranchTakenD  = 1'b1;
        BranchTargetD = 32'h18;
        imem_rdata    = 32'h3333_3333;
        #1;
        chk("coll_instr", InstructionF, 32'h3333_3333);
        step();
        chk("coll_pcf",  PCF, 32'h14);
        chk("coll_scnt", stall_cnt, 32'd2);
        isLWHazard = 1'b0;
        #1;
        chk("coll2_instr", InstructionF, 32'h0);
        step();
        chk("coll2_pcf",  PCF, 32'h18);
        chk("coll2_fcnt", fetch_cnt, 32'd4);
        clr_in();

        // Halt word under a stall is not a halt
        isLWHazard = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("hz_halt_stopf", 32'(StopF), 32'h0);
        step();
        chk("hz_halt_halted", 32'(halted), 32'h0);
        chk("hz_halt_scnt",   stall_cnt, 32'd3);

        // Halt word seen at PCF=18
        isLWHazard = 1'b0;
        #1;
        chk("halt_stopf",  32'(StopF), 32'h1);
        chk("halt_instr",  InstructionF, 32'h0);
        chk("halt_hlt_n",  32'(halted), 32'h0);
        step();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_pcf",    PCF, 32'h18);
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            isLWHazard  = i[0];
            JumpD       = ~i[0];
            JumpTargetD = 32'h300;
            #1;
            chk("hold_stopf", 32'(StopF), 32'h1);
            chk("hold_instr", InstructionF, 32'h0);
            step();
            chk("hold_pcf", PCF, 32'h18);
        end
        chk("hold_fcnt",   fetch_cnt, 32'd4);
        chk("hold_scnt",   stall_cnt, 32'd3);
        chk("hold_halted", 32'(halted), 32'h1);

        // Reset while halted, with other inputs active
        reset = 1'b0;
        step();
        reset = 1'b1;
        clr_in();
        chk("rst2_pcf",    PCF, 32'h0);
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_fcnt",   fetch_cnt, 32'h0);
        chk("rst2_scnt",   stall_cnt, 32'h0);

        // PC wrap at the top of the address space
        JumpD       = 1'b1;
        JumpTargetD = 32'hFFFF_FFFF;
        step();
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        clr_in();
        imem_rdata = 32'h0000_0013;
        #1;
        chk("wrap_pc4", PC4, 32'h0);
        step();
        chk("wrap_next_pcf", PCF, 32'h0);
        chk("wrap_fcnt",     fetch_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
